fp_sqrt_sequencer: RTL

//  Top-level control FSM for the single-precision FP square-root datapath.
//  - Accepts a start request and classifies the operand from datapath flags.
//  - Either selects a special result or runs ITER_N restoring shift/subtract/test iterations.
//  - Then rounds, writes the result and pulses Done_o.
//  - Sits between the host handshake and the FP_Datapath control inputs.

---
 rtl/fp_sqrt_pkg.sv | 36 +++
 rtl/sqrt_iter_cnt.sv | 33 +++
 rtl/fp_sqrt_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared state encoding, result-select codes and special-operand priority
// for the FP square-root sequencer.
package fp_sqrt_pkg;

   localparam int ITER_N_DEF = 26;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_LOAD     = 4'd1,
      S_CLASSIFY = 4'd2,
      S_PREP     = 4'd3,
      S_SUB      = 4'd4,
      S_TEST     = 4'd5,
      S_ROUND    = 4'd6,
      S_SPECIAL  = 4'd7,
      S_DONE     = 4'd8
   } state_e;

   localparam logic [1:0] SEL_ROOT = 2'b00;
   localparam logic [1:0] SEL_ZERO = 2'b01;
   localparam logic [1:0] SEL_INF  = 2'b10;
   localparam logic [1:0] SEL_NAN  = 2'b11;

   // Zero wins over sign so that sqrt(-0) returns -0 rather than NaN.
   function automatic logic [1:0] special_sel(input logic nan, input logic zero,
                                              input logic neg, input logic inf);
      logic [1:0] sel;
      if (nan)       sel = SEL_NAN;
      else if (zero) sel = SEL_ZERO;
      else if (neg)  sel = SEL_NAN;
      else if (inf)  sel = SEL_INF;
      else           sel = SEL_ROOT;
      return sel;
   endfunction

endpackage

// File: rtl/sqrt_iter_cnt.sv
// Iteration down-counter: loads ITER_N-1, decrements once per TEST cycle,
// and flags the last iteration.
module sqrt_iter_cnt #(
   parameter int  ITER_N = 26,
   localparam int CNT_W  = $clog2(ITER_N)
) (
   input  logic             Clk_i,
   input  logic             nRst_i,
   input  logic             i_load,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // Counter register; load has priority over decrement.
   always_ff @(posedge Clk_i or negedge nRst_i) begin
      if (!nRst_i) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= CNT_W'(ITER_N - 1);
      end else if (i_dec) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fp_sqrt_sequencer.sv
// Control FSM for the single-precision square-root datapath: classify,
// run ITER_N restoring iterations or pick a special result, round, write, done.
module fp_sqrt_sequencer
   import fp_sqrt_pkg::*;
#(
   parameter int  ITER_N = ITER_N_DEF,
   localparam int CNT_W  = $clog2(ITER_N)
) (
   input  logic             Clk_i,
   input  logic             nRst_i,
   input  logic             Start_i,
   input  logic             IsNaN_i,
   input  logic             IsInf_i,
   input  logic             IsZero_i,
   input  logic             IsNeg_i,
   input  logic             ExpOdd_i,
   input  logic             Negative_i,
   output logic             Ready_o,
   output logic             Busy_o,
   output logic             LoadOp_o,
   output logic             ExpHalve_o,
   output logic             MantShift_o,
   output logic             IterSub_o,
   output logic             Restore_o,
   output logic             QShift_o,
   output logic             QBit_o,
   output logic [CNT_W-1:0] IterIdx_o,
   output logic             Round_o,
   output logic             WrResult_o,
   output logic [1:0]       SelSpecial_o,
   output logic             Done_o,
   output logic [3:0]       State_o
);

   state_e           r_state;
   logic [1:0]       r_sel;
   logic             w_special;
   logic [1:0]       w_sel;
   logic             w_cnt_zero;
   logic [CNT_W-1:0] w_cnt;

   assign w_special = IsNaN_i | IsInf_i | IsZero_i | IsNeg_i;
   assign w_sel     = special_sel(IsNaN_i, IsZero_i, IsNeg_i, IsInf_i);

   sqrt_iter_cnt #(.ITER_N(ITER_N)) u_cnt (
      .Clk_i  (Clk_i),
      .nRst_i (nRst_i),
      .i_load (r_state == S_PREP),
      .i_dec  ((r_state == S_TEST) && !w_cnt_zero),
      .o_cnt  (w_cnt),
      .o_zero (w_cnt_zero)
   );

   // State register; the special-result code is captured only in CLASSIFY.
   always_ff @(posedge Clk_i or negedge nRst_i) begin
      if (!nRst_i) begin
         r_state <= S_IDLE;
         r_sel   <= SEL_ROOT;
      end else begin
         case (r_state)
            S_IDLE:     r_state <= Start_i ? S_LOAD : S_IDLE;
            S_LOAD:     r_state <= S_CLASSIFY;
            S_CLASSIFY: begin
               r_state <= w_special ? S_SPECIAL : S_PREP;
               r_sel   <= w_sel;
            end
            S_PREP:     r_state <= S_SUB;
            S_SUB:      r_state <= S_TEST;
            S_TEST:     r_state <= w_cnt_zero ? S_ROUND : S_SUB;
            S_ROUND:    r_state <= S_DONE;
            S_SPECIAL:  r_state <= S_DONE;
            S_DONE:     r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   // Output decode; only MantShift, QBit and Restore look at live datapath flags.
   always_comb begin
      Ready_o      = (r_state == S_IDLE);
      Busy_o       = (r_state != S_IDLE);
      LoadOp_o     = (r_state == S_LOAD);
      ExpHalve_o   = (r_state == S_PREP);
      MantShift_o  = (r_state == S_PREP) && ExpOdd_i;
      IterSub_o    = (r_state == S_SUB);
      QShift_o     = (r_state == S_TEST);
      QBit_o       = (r_state == S_TEST) && !Negative_i;
      Restore_o    = (r_state == S_TEST) && Negative_i;
      Round_o      = (r_state == S_ROUND);
      WrResult_o   = (r_state == S_ROUND) || (r_state == S_SPECIAL);
      SelSpecial_o = (r_state == S_SPECIAL) ? r_sel : SEL_ROOT;
      Done_o       = (r_state == S_DONE);
      IterIdx_o    = w_cnt;
      State_o      = r_state;
   end

endmodule
